// File: rtl/sram_like_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_bridge
// Purpose  : Bridges a pipeline stage's single-cycle SRAM port
//            (en/wen/addr/wdata, rdata one cycle later) to a split-handshake
//            sram-like bus (req/addr_ok/data_ok). It keeps one access
//            outstanding at a time and raises stallreq to CTRL while that
//            access is in flight.
// Ports    : clk, rst (async, active-high)
//            core side : core_en, core_wen, core_addr, core_wdata -> core_rdata
//            ctrl      : stallreq
//            bus side  : req, wr, size, wstrb, addr, wdata <- addr_ok,
//                        data_ok, rdata
//            optional  : timeout_err (SRAM_BRIDGE_TIMEOUT_EN only)
// Options  : `define SRAM_BRIDGE_TIMEOUT_EN adds a WAIT-state watchdog of
//            TIMEOUT_CYC cycles and the timeout_err pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_en,
  input  logic [DATA_W/8-1:0] core_wen,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                stallreq,
  output logic                req,
  output logic                wr,
  output logic [2:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
`ifdef SRAM_BRIDGE_TIMEOUT_EN
  output logic                timeout_err,
`endif
  input  logic [DATA_W-1:0]   rdata
);

  localparam int       STRB_W    = DATA_W / 8;
  localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_W));

  // Elaboration-time parameter legality checks.
  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("sram_like_bridge: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("sram_like_bridge: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_q;
  logic                  req_q;
  logic                  wr_q;
  logic [2:0]            size_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     core_rdata_q;
  logic [2:0]            size_d;
  logic [3:0]            wen_cnt;
  logic                  timeout_hit;

  // Access size from the byte-enable pattern: a read is always full width;
  // a write of 1/2/4/8 lanes maps to its log2, anything else is full width.
  always_comb begin
    wen_cnt = 4'd0;
    for (int i = 0; i < STRB_W; i++) begin
      wen_cnt = wen_cnt + {3'b000, core_wen[i]};
    end
    case (wen_cnt)
      4'd1:    size_d = 3'd0;
      4'd2:    size_d = 3'd1;
      4'd4:    size_d = 3'd2;
      4'd8:    size_d = 3'd3;
      default: size_d = FULL_SIZE;
    endcase
  end

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;

  // A data_ok in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q == WAIT) && !data_ok &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYC));
  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      wr_q          <= 1'b0;
      size_q        <= 3'd0;
      wstrb_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      core_rdata_q  <= '0;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef SRAM_BRIDGE_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (core_en) begin
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
            wstrb_q <= core_wen;
            wr_q    <= |core_wen;
            size_q  <= size_d;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Bus fields stay frozen until the address is accepted.
          if (addr_ok) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        WAIT: begin
          if (data_ok) begin
            if (!wr_q) begin
              core_rdata_q <= rdata;
            end
            state_q <= IDLE;
          end
`ifdef SRAM_BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            core_rdata_q  <= '1;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drops in the data_ok (or expiry) cycle so the held instruction
  // advances on that same edge.
  assign stallreq = ((state_q == IDLE) && core_en) ||
                    (state_q == REQ) ||
                    ((state_q == WAIT) && !data_ok && !timeout_hit);

  assign req        = req_q;
  assign wr         = wr_q;
  assign size       = size_q;
  assign wstrb      = wstrb_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign core_rdata = core_rdata_q;

endmodule
`default_nettype wire

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Parametrised bridge between a pipeline stage's single-cycle SRAM port (en/wen/addr/wdata, rdata one cycle later) and a split-handshake sram-like bus (req/addr_ok/data_ok).
- Lets IF/EX talk to memories with variable latency.
- Raises a stall request to CTRL while an access is outstanding.
- One instance per channel (inst, data); width generalised for the 64-bit datapath.

Parameters:
- DATA_W, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- TIMEOUT_CYC, 255, WAIT-state cycle limit; used only with SRAM_BRIDGE_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- core_en  input  1  access request from pipeline; held high for the whole stall.
- core_wen  input  DATA_W/8  byte write enables; all zero means read.
- core_addr  input  ADDR_W  access address.
- core_wdata  input  DATA_W  store data, byte-lane aligned.
- core_rdata  output  DATA_W  registered read data.
- stallreq  output  1  stall request to CTRL.
- req  output  1  bus request valid.
- wr  output  1  1 = write, 0 = read.
- size  output  3  log2 of access bytes.
- wstrb  output  DATA_W/8  registered copy of core_wen.
- addr  output  ADDR_W  bus address.
- wdata  output  DATA_W  bus write data.
- addr_ok  input  1  bus accepts address (handshake completes when req && addr_ok).
- data_ok  input  1  bus returns data or write acknowledge.
- rdata  input  DATA_W  bus read data, valid with data_ok.
- timeout_err  output  1  one-cycle pulse; exists only with SRAM_BRIDGE_TIMEOUT_EN.

Behaviour:
- States: IDLE, REQ, WAIT. Reset value: IDLE.
- Reset values: req=0, wr=0, size=0, wstrb=0, addr=0, wdata=0, core_rdata=0, timeout_err=0.
- IDLE with core_en=1:
  - Capture addr, wdata and wstrb; set wr = |core_wen.
  - size: read = log2(DATA_W/8). Write = popcount(core_wen) mapped 1→0, 2→1, 4→2, 8→3. Any other wen pattern is treated as a full-width write.
  - Next state REQ.
- REQ:
  - req=1, all bus outputs stable.
  - addr_ok=1 → WAIT, req drops the next cycle.
  - addr_ok=0 → stay in REQ.
  - data_ok is ignored in REQ.
- WAIT:
  - req=0.
  - data_ok=1 → latch rdata into core_rdata on reads only (writes leave core_rdata unchanged); next state IDLE.
- stallreq (combinational) = (IDLE && core_en) || REQ || (WAIT && !data_ok).
  - It drops in the data_ok cycle, so the stalled instruction advances on that edge.
  - core_rdata is valid from the next cycle and holds until the next read's data_ok.
- Minimum latency: en at cycle N, req at N+1 with addr_ok at N+1, data_ok at N+2, core_rdata valid at N+3.
  - stallreq is high for N and N+1, low at N+2.
- Only one outstanding transaction. core_en in REQ or WAIT is the same held access and is never reissued.
- core_en in the cycle after return to IDLE is a new access.
- core_en=0 in IDLE: no bus activity, stallreq=0.
- Reset mid-transaction:
  - Immediate asynchronous return to IDLE, req=0.
  - Any late data_ok after reset is ignored because the bridge is in IDLE.

Optional Feature:
- Macro SRAM_BRIDGE_TIMEOUT_EN.
- Defined:
  - Add an 8-bit-minimum counter, cleared on WAIT entry and incremented each WAIT cycle without data_ok.
  - When the counter reaches TIMEOUT_CYC: go to IDLE, force stallreq low that cycle, load core_rdata with all-ones, and pulse timeout_err for one cycle.
  - A data_ok in the same cycle as expiry wins; no error.
- Undefined: no counter, no timeout_err port, WAIT lasts indefinitely.

Test Plan:
- Read, DATA_W=32, en at cycle 0, addr 0x1000, addr_ok at cycle 1, data_ok at cycle 3 with rdata 0x12345678:
  - req=1 only at cycle 1; stallreq=1 at cycles 0–2, 0 at cycle 3.
  - core_rdata=0x12345678 from cycle 4.
- Byte write, wen=0010, addr 0x2001, wdata 0x0000AB00, addr_ok held low 3 cycles:
  - req held 3+ cycles with wr=1, size=0, wstrb=0010, addr/wdata stable.
  - core_rdata unchanged.
- DATA_W=64 read with wen=0: size=3. Half write wen=00110000: size=1.
- Back-to-back reads, second en the cycle after the first data_ok: second req issued, no duplicate of the first; exactly two req handshakes counted.
- Assert rst in WAIT, then data_ok the cycle after release: state IDLE, req=0, core_rdata=0, stallreq=0.
- With SRAM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=4, data_ok never arrives:
  - timeout_err pulses once, 4 cycles after WAIT entry.
  - core_rdata=0xFFFFFFFF, stallreq drops, state returns to IDLE.
